// File: rtl/mips32_pkg.sv
// -----------------------------------------------------------------------------
// mips32_pkg
//   Shared types for the MIPS32 memory arbiter slice.
//   port_e    : requester identifier used by the grant selector and the
//               response tag (NONE, IF, DM, DBG).
//   rsp_tag_t : one-cycle response tag {port, is_read} used to route
//               mem_rdata back to the requester that issued the read.
// -----------------------------------------------------------------------------
package mips32_pkg;

    typedef enum logic [1:0] {
        PORT_NONE = 2'd0,
        PORT_IF   = 2'd1,
        PORT_DM   = 2'd2,
        PORT_DBG  = 2'd3
    } port_e;

    typedef struct packed {
        port_e port;
        logic  is_read;
    } rsp_tag_t;

    localparam rsp_tag_t RSP_TAG_IDLE = '{port: PORT_NONE, is_read: 1'b0};

endpackage

// File: rtl/mips32_arb_prio.sv
// -----------------------------------------------------------------------------
// mips32_arb_prio
//   Combinational grant selector for the shared memory port.
//   Priority: dbg > (if when starved) > dm > if.
// Ports:
//   if_req_i, dm_req_i, dbg_req_i : request lines (already qualified)
//   starved_i                     : IF has been denied STARVE_LIMIT times
//   sel_o                         : granted port, PORT_NONE when idle
// -----------------------------------------------------------------------------
module mips32_arb_prio
    import mips32_pkg::*;
(
    input  logic  if_req_i,
    input  logic  dm_req_i,
    input  logic  dbg_req_i,
    input  logic  starved_i,
    output port_e sel_o
);

    always_comb begin
        sel_o = PORT_NONE;
        if (dbg_req_i) begin
            sel_o = PORT_DBG;
        end else if (if_req_i && starved_i) begin
            sel_o = PORT_IF;
        end else if (dm_req_i) begin
            sel_o = PORT_DM;
        end else if (if_req_i) begin
            sel_o = PORT_IF;
        end
    end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// mips32_mem_arbiter
//   Arbitrates an instruction-fetch port (read-only) and a data port onto one
//   single-port synchronous memory. One access per cycle; grant and mem_*
//   are combinational, read data returns on the granting port one cycle later.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   if_req/addr, if_gnt/rvalid/rdata           : instruction fetch port
//   dm_req/we/addr/wdata, dm_gnt/rvalid/rdata  : data port
//   mem_en/we/addr/wdata, mem_rdata            : shared memory port
//   starve_cnt                 : consecutive IF denials (saturating)
//   busy                       : grant issued or read response in flight
// Configuration:
//   MEM_ARB_DBG_PORT_EN        : adds a debug port with absolute priority
// -----------------------------------------------------------------------------
module mips32_mem_arbiter
    import mips32_pkg::*;
#(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              if_req,
    input  logic [ADDR_W-1:0]                 if_addr,
    output logic                              if_gnt,
    output logic                              if_rvalid,
    output logic [DATA_W-1:0]                 if_rdata,
    input  logic                              dm_req,
    input  logic                              dm_we,
    input  logic [ADDR_W-1:0]                 dm_addr,
    input  logic [DATA_W-1:0]                 dm_wdata,
    output logic                              dm_gnt,
    output logic                              dm_rvalid,
    output logic [DATA_W-1:0]                 dm_rdata,
    output logic                              mem_en,
    output logic                              mem_we,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic [DATA_W-1:0]                 mem_wdata,
    input  logic [DATA_W-1:0]                 mem_rdata,
`ifdef MEM_ARB_DBG_PORT_EN
    input  logic                              dbg_req,
    input  logic                              dbg_we,
    input  logic [ADDR_W-1:0]                 dbg_addr,
    input  logic [DATA_W-1:0]                 dbg_wdata,
    output logic                              dbg_gnt,
    output logic                              dbg_rvalid,
    output logic [DATA_W-1:0]                 dbg_rdata,
`endif
    output logic [$clog2(STARVE_LIMIT+1)-1:0] starve_cnt,
    output logic                              busy
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    rsp_tag_t         tag_q, tag_d;
    port_e            sel;
    logic             dbg_req_w;

`ifdef MEM_ARB_DBG_PORT_EN
    assign dbg_req_w = dbg_req;
`else
    assign dbg_req_w = 1'b0;
`endif

    // Requests are masked while reset is asserted so grants and mem_en
    // drop asynchronously together with the registered state.
    mips32_arb_prio u_prio (
        .if_req_i  (if_req    & rst_n),
        .dm_req_i  (dm_req    & rst_n),
        .dbg_req_i (dbg_req_w & rst_n),
        .starved_i (starve_cnt_q == LIMIT_C),
        .sel_o     (sel)
    );

    always_comb begin
        if_gnt    = 1'b0;
        dm_gnt    = 1'b0;
`ifdef MEM_ARB_DBG_PORT_EN
        dbg_gnt   = 1'b0;
`endif
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        tag_d     = RSP_TAG_IDLE;
        unique case (sel)
            PORT_IF: begin
                if_gnt   = 1'b1;
                mem_en   = 1'b1;
                mem_addr = if_addr;
                tag_d    = '{port: PORT_IF, is_read: 1'b1};
            end
            PORT_DM: begin
                dm_gnt    = 1'b1;
                mem_en    = 1'b1;
                mem_we    = dm_we;
                mem_addr  = dm_addr;
                mem_wdata = dm_wdata;
                tag_d     = '{port: PORT_DM, is_read: !dm_we};
            end
`ifdef MEM_ARB_DBG_PORT_EN
            PORT_DBG: begin
                dbg_gnt   = 1'b1;
                mem_en    = 1'b1;
                mem_we    = dbg_we;
                mem_addr  = dbg_addr;
                mem_wdata = dbg_wdata;
                tag_d     = '{port: PORT_DBG, is_read: !dbg_we};
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req || if_gnt) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != LIMIT_C) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            tag_q        <= RSP_TAG_IDLE;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            tag_q        <= tag_d;
        end
    end

    assign if_rvalid  = tag_q.is_read && (tag_q.port == PORT_IF);
    assign dm_rvalid  = tag_q.is_read && (tag_q.port == PORT_DM);
    assign if_rdata   = if_rvalid ? mem_rdata : '0;
    assign dm_rdata   = dm_rvalid ? mem_rdata : '0;
`ifdef MEM_ARB_DBG_PORT_EN
    assign dbg_rvalid = tag_q.is_read && (tag_q.port == PORT_DBG);
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
`endif

    assign starve_cnt = starve_cnt_q;
    // A set is_read always names exactly one port, so it covers every rvalid.
    assign busy       = mem_en | tag_q.is_read;

endmodule
